// File: rtl/tlight_lamp_monitor_pkg.sv
// Shared lamp encodings, fault codes and lane indices for the lamp monitor.
package tlight_pkg;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    typedef enum logic [2:0] {
        F_NONE     = 3'd0,
        F_ENC      = 3'd1,
        F_CONFLICT = 3'd2,
        F_SEQ      = 3'd3,
        F_SHORT_Y  = 3'd4,
        F_SHORT_G  = 3'd5,
        F_STUCK    = 3'd6
    } fault_e;

    typedef enum logic [1:0] {
        L_M1 = 2'd0,
        L_M2 = 2'd1,
        L_MT = 2'd2,
        L_S  = 2'd3
    } lane_e;

    // A lamp bus is legal only when exactly one of R, Y, G is lit.
    function automatic logic lamp_legal(input logic [2:0] v);
        return (v == LAMP_R) || (v == LAMP_Y) || (v == LAMP_G);
    endfunction

    // Lowest-numbered lane flagged in a per-lane vector.
    function automatic lane_e lowest_lane(input logic [3:0] v);
        if (v[0])      return L_M1;
        else if (v[1]) return L_M2;
        else if (v[2]) return L_MT;
        else           return L_S;
    endfunction

endpackage

// File: rtl/tlight_lamp_monitor_if.sv
// Lamp buses from the intersection controller plus the monitor's fault/status outputs.
interface tlight_lamp_monitor_if #(
    parameter int CNT_W = 16
);
    logic [2:0]       m1;
    logic [2:0]       m2;
    logic [2:0]       mt;
    logic [2:0]       s;
    logic             clr;
    logic             fault;
    logic [2:0]       fault_code;
    logic [1:0]       fault_lane;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output m1, m2, mt, s, clr,
        input  fault, fault_code, fault_lane, cycle_cnt
    );

    modport slave (
        input  m1, m2, mt, s, clr,
        output fault, fault_code, fault_lane, cycle_cnt
    );
endinterface

// File: rtl/tlight_lamp_monitor_lane_chk.sv
// Per-lane checker: encoding, transition legality and minimum phase durations.
module tlight_lane_chk
    import tlight_pkg::*;
#(
    parameter int TW      = 8,
    parameter int MIN_GRN = 5,
    parameter int MIN_YEL = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] lamp_i,
    output logic       enc_err_o,
    output logic       seq_err_o,
    output logic       short_y_o,
    output logic       short_g_o,
    output logic       active_o,
    output logic       changed_o,
    output logic       y2r_o
);

    logic [2:0]    prev_q, prev_d;
    logic [TW-1:0] dur_q, dur_d;
    logic [2:0]    cur;
    logic          r2g, g2y, y2r;

    // Classify the current sample against the stored previous state.
    always_comb begin
        enc_err_o = !lamp_legal(lamp_i);
        // An illegal bus is treated as red so later transitions are judged from a safe state.
        cur       = enc_err_o ? LAMP_R : lamp_i;
        changed_o = (cur != prev_q);
        r2g       = (prev_q == LAMP_R) && (cur == LAMP_G);
        g2y       = !enc_err_o && (prev_q == LAMP_G) && (cur == LAMP_Y);
        y2r       = !enc_err_o && (prev_q == LAMP_Y) && (cur == LAMP_R);
        active_o  = !enc_err_o && ((cur == LAMP_G) || (cur == LAMP_Y));
        seq_err_o = !enc_err_o && changed_o && !(r2g || g2y || y2r);
        short_y_o = y2r && (dur_q < TW'(MIN_YEL));
        short_g_o = g2y && (dur_q < TW'(MIN_GRN));
        y2r_o     = y2r;
        prev_d    = cur;
        if (changed_o)
            dur_d = TW'(1);
        else if (dur_q != {TW{1'b1}})
            dur_d = dur_q + TW'(1);
        else
            dur_d = dur_q;
    end

    // Previous lamp state and saturating time-in-state counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= LAMP_R;
            dur_q  <= '0;
        end else begin
            prev_q <= prev_d;
            dur_q  <= dur_d;
        end
    end

endmodule

// File: rtl/tlight_lamp_monitor.sv
// Lamp bus monitor: per-lane checks, conflict matrix, watchdog, first-fault latch and side-cycle counter.
module tlight_lamp_monitor
    import tlight_pkg::*;
#(
    parameter int MIN_GRN = 5,
    parameter int MIN_YEL = 2,
    parameter int WDOG    = 60,
    parameter int TW      = 8,
    parameter int CNT_W   = 16
) (
    input logic                 clk,
    input logic                 r,
    tlight_lamp_monitor_if.slave bus
);

    localparam int WD_W = $clog2(WDOG + 1);

    logic [2:0] lamp [4];
    logic [3:0] enc_err, seq_err, short_y, short_g, active, changed, y2r;
    logic [3:0] conflict;
    logic       any_change, stuck, new_flt;
    fault_e     code_n;
    lane_e      lane_n;

    logic             fault_q, fault_d;
    fault_e           code_q, code_d;
    lane_e            lane_q, lane_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;

    // Only the side road's Y->R transition closes a counted cycle.
    logic unused_y2r;
    assign unused_y2r = ^y2r[2:0];

    assign lamp[0] = bus.m1;
    assign lamp[1] = bus.m2;
    assign lamp[2] = bus.mt;
    assign lamp[3] = bus.s;

    for (genvar g = 0; g < 4; g++) begin : g_lane
        tlight_lane_chk #(
            .TW      (TW),
            .MIN_GRN (MIN_GRN),
            .MIN_YEL (MIN_YEL)
        ) u_chk (
            .clk       (clk),
            .rst_n     (r),
            .lamp_i    (lamp[g]),
            .enc_err_o (enc_err[g]),
            .seq_err_o (seq_err[g]),
            .short_y_o (short_y[g]),
            .short_g_o (short_g[g]),
            .active_o  (active[g]),
            .changed_o (changed[g]),
            .y2r_o     (y2r[g])
        );
    end

    // Conflicts, watchdog and priority selection of this cycle's fault.
    always_comb begin
        // s clashes with any main lane; mt clashes with m2. Conflicts involving s are blamed on s.
        conflict   = {active[3] & (|active[2:0]), active[2] & active[1], 2'b00};
        any_change = |changed;
        // Fires once, on the sample that brings the idle count up to WDOG.
        stuck      = !any_change && (wdog_q == WD_W'(WDOG - 1));
        if (any_change)
            wdog_d = '0;
        else if (wdog_q != WD_W'(WDOG))
            wdog_d = wdog_q + WD_W'(1);
        else
            wdog_d = wdog_q;

        new_flt = 1'b1;
        code_n  = F_NONE;
        lane_n  = L_M1;
        if (|enc_err) begin
            code_n = F_ENC;
            lane_n = lowest_lane(enc_err);
        end else if (|conflict) begin
            code_n = F_CONFLICT;
            lane_n = lowest_lane(conflict);
        end else if (|seq_err) begin
            code_n = F_SEQ;
            lane_n = lowest_lane(seq_err);
        end else if (|short_y) begin
            code_n = F_SHORT_Y;
            lane_n = lowest_lane(short_y);
        end else if (|short_g) begin
            code_n = F_SHORT_G;
            lane_n = lowest_lane(short_g);
        end else if (stuck) begin
            code_n = F_STUCK;
            lane_n = L_M1;
        end else begin
            new_flt = 1'b0;
        end
    end

    // First-fault latch (a fresh fault beats clr) and side-cycle counter next state.
    always_comb begin
        fault_d = fault_q;
        code_d  = code_q;
        lane_d  = lane_q;
        if (new_flt && (!fault_q || bus.clr)) begin
            fault_d = 1'b1;
            code_d  = code_n;
            lane_d  = lane_n;
        end else if (bus.clr) begin
            fault_d = 1'b0;
            code_d  = F_NONE;
            lane_d  = L_M1;
        end
        cnt_d = cnt_q + CNT_W'(y2r[3]);
    end

    // Registered status outputs and watchdog.
    always_ff @(posedge clk or negedge r) begin
        if (!r) begin
            fault_q <= 1'b0;
            code_q  <= F_NONE;
            lane_q  <= L_M1;
            cnt_q   <= '0;
            wdog_q  <= '0;
        end else begin
            fault_q <= fault_d;
            code_q  <= code_d;
            lane_q  <= lane_d;
            cnt_q   <= cnt_d;
            wdog_q  <= wdog_d;
        end
    end

    assign bus.fault      = fault_q;
    assign bus.fault_code = code_q;
    assign bus.fault_lane = lane_q;
    assign bus.cycle_cnt  = cnt_q;

endmodule
